turbo_encoder: RTL
==================

# turbo_encoder

Rate-1/3-plus-tail parallel turbo encoder for the 5-bit-block decoder chain. It accepts one 5-bit message block over a valid/ready handshake and runs two identical 4-state recursive systematic convolutional (RSC) encoders, one trellis step per cycle. Encoder 1 sees natural order; encoder 2 sees interleaved order. Both trellises are terminated with 2 tail steps. The block emits four 28-bit words of 4-bit signed antipodal symbols (7 per word), packed exactly as the SISO decoder's `sys_i` / `enc_i` inputs expect.

## Interface
- `AMP`, 4'sd7: symbol magnitude; legal range 1..7.
- `PERM`, 15'b011_000_010_100_001: interleaver; `PERM[3k+2:3k]` is the source index for interleaved position k (default π = 1,4,2,0,3).
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  reset: asynchronous, active-low.
- `valid_i`  in  1  block offered.
- `ready_o`  out  1  encoder idle; block accepted on `valid_i & ready_o`.
- `data_i`  in  5  message bits; u[k] = `data_i[4-k]`.
- `valid_o`  out  1  output words valid.
- `ready_i`  in  1  consumer accepts on `valid_o & ready_i`.
- `sys1_o`  out  28  systematic symbols, natural order plus encoder-1 tail.
- `par1_o`  out  28  encoder-1 parity symbols.
- `sys2_o`  out  28  interleaved systematic symbols plus encoder-2 tail.
- `par2_o`  out  28  encoder-2 parity symbols.

## Operation
- Symbol k (0..6) is located at bits [27-4k : 24-4k], so index 0 is in the MSBs.
- Mapping: bit 1 → +AMP, bit 0 → −AMP, two's complement. With AMP=7: 1 → 4'h7, 0 → 4'h9.
- RSC state s = {s1, s0}, initialised to 0 at each accept.
- Each step with input bit u:
  - feedback a = u ^ s0
  - parity p = a
  - next state = {a, s1}
- Steps k=0..4 use message bits:
  - encoder 1 input is u[k]
  - encoder 2 input is u[PERM field k]
- Tail steps k=5,6: each encoder independently uses u = its own s0. This forces a=0 and p=0, so both encoders end in state 0. The tail u is recorded as that encoder's systematic bit.
- FSM states:
  - IDLE: `ready_o`=1. Accept → ENCODE, step=0, both encoder states cleared.
  - ENCODE: one step per edge. After step 4 → TAIL.
  - TAIL: steps 5,6. After step 6 → DONE.
  - DONE: `valid_o`=1. `valid_o & ready_i` → IDLE.
- Output word registers shift one symbol per step. They are stable and held throughout DONE.
- `valid_i` is ignored outside IDLE.
- `data_i` is latched at accept; later changes have no effect.

## Timing
- Reset values:
  - state IDLE
  - `ready_o`=1, `valid_o`=0
  - all four data outputs 28'h0
  - step counter 0, encoder states 0
- Accept at edge E0. Steps occur at E1..E7. `valid_o` rises after E7.
- Latency from accept to output valid: 7 cycles.
- If `ready_i` is high in DONE, the handoff happens at E8. `ready_o` rises after E8, and the next accept is at E9 at the earliest. Minimum period: 9 cycles per block.
- Backpressure: while `ready_i`=0, DONE is held indefinitely with outputs unchanged.
- Reset asserted mid-block: immediate return to reset values. The partial block is discarded and no `valid_o` pulse occurs.
- `valid_i` held high continuously: exactly one block is accepted per IDLE visit.

## Structure
- Package `turbo_pkg` holds:
  - FSM state enum
  - INPUT_SIZE=5, EXTEND_SIZE=7, SYM_W=4, WORD_W=28
  - the `sym_map(bit, AMP)` function
- Sub-module `turbo_rsc_step`: purely combinational, (s, u, tail) → (u_eff, p, s_next). Instantiated twice.
- Top-level `turbo_encoder` owns:
  - FSM and step counter
  - latched message and interleave mux
  - per-encoder state registers
  - output shift registers

## Test plan
- Reset check: reset held, then released → `ready_o`=1, `valid_o`=0, all outputs 0. After reset, IDLE with no `valid_i` for 20 cycles → no change.
- All-zero block: `data_i`=5'b00000 → `valid_o` 7 cycles after accept; all four words = 28'h9999999.
- Single one: `data_i`=5'b10000 → expected words:
  - `sys1_o` = 28'h7999997
  - `par1_o` = 28'h7979799
  - `sys2_o` = 28'h9997979
  - `par2_o` = 28'h9997999
- Backpressure: repeat the previous block with `ready_i`=0 for 10 cycles in DONE → outputs held, `ready_o`=0, a new `valid_i` is ignored. Then `ready_i`=1 → handoff, and the next accept occurs 9 cycles after the prior accept at the earliest.
- Reset mid-operation: assert `reset_n_i` low at step 3 → outputs return to 0 asynchronously. A subsequent 5'b00000 block encodes correctly (28'h9999999 on all four words).
- Random blocks (all 32 values): compare against a reference model, including the tail-termination check that both encoders end in state 0.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared types and constants for the turbo encoder.
// Holds the FSM state enum, block/word sizes and the symbol mapper.
package turbo_pkg;

    localparam int INPUT_SIZE  = 5;
    localparam int EXTEND_SIZE = 7;
    localparam int SYM_W       = 4;
    localparam int WORD_W      = 28;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENCODE,
        S_TAIL,
        S_DONE
    } state_t;

    // 1 -> +amp, 0 -> -amp, two's complement
    function automatic logic [SYM_W-1:0] sym_map(
        input logic              b,
        input logic [SYM_W-1:0]  amp
    );
        return b ? amp : (~amp + 1'b1);
    endfunction

endpackage

// File: rtl/turbo_rsc_step.sv
// One trellis step of the 4-state recursive systematic encoder.
// Ports: s (state {s1,s0}), u (input bit), tail (terminating step),
// u_eff (systematic bit used), p (parity), s_next (next state).
module turbo_rsc_step (
    input  logic [1:0] s,
    input  logic       u,
    input  logic       tail,
    output logic       u_eff,
    output logic       p,
    output logic [1:0] s_next
);

    logic a;

    // tail steps feed s0 back so the feedback bit cancels to zero
    assign u_eff  = tail ? s[0] : u;
    assign a      = u_eff ^ s[0];
    assign p      = a;
    assign s_next = {a, s[1]};

endmodule

// File: rtl/turbo_encoder.sv
// Rate-1/3 parallel turbo encoder with two terminated 4-state RSCs.
// Ports: clk_i, reset_n_i, valid_i/ready_o/data_i (block in),
// valid_o/ready_i (words out), sys1_o, par1_o, sys2_o, par2_o.
module turbo_encoder
    import turbo_pkg::*;
#(
    parameter logic signed [3:0] AMP  = 4'sd7,
    parameter logic [14:0]       PERM = 15'b011_000_010_100_001
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [4:0]  data_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [27:0] sys1_o,
    output logic [27:0] par1_o,
    output logic [27:0] sys2_o,
    output logic [27:0] par2_o
);

    localparam logic [2:0] LAST_MSG  = 3'd4;
    localparam logic [2:0] LAST_TAIL = 3'd6;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  step_q;
    logic [4:0]  msg_q;
    logic [4:0]  u_nat;
    logic [1:0]  enc1_s_q;
    logic [1:0]  enc2_s_q;
    logic [27:0] sys1_q;
    logic [27:0] par1_q;
    logic [27:0] sys2_q;
    logic [27:0] par2_q;

    logic        step_en;
    logic        tail_en;
    logic        accept;
    logic [2:0]  src2;
    logic        u1;
    logic        u2;
    logic        u1_eff;
    logic        u2_eff;
    logic        p1;
    logic        p2;
    logic [1:0]  enc1_s_d;
    logic [1:0]  enc2_s_d;

    // ---------------- FSM: state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (valid_i) state_d = S_ENCODE;
            end
            S_ENCODE: begin
                if (step_q == LAST_MSG) state_d = S_TAIL;
            end
            S_TAIL: begin
                if (step_q == LAST_TAIL) state_d = S_DONE;
            end
            S_DONE: begin
                if (ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs
    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        step_en = 1'b0;
        tail_en = 1'b0;
        unique case (state_q)
            S_IDLE:   ready_o = 1'b1;
            S_ENCODE: step_en = 1'b1;
            S_TAIL: begin
                step_en = 1'b1;
                tail_en = 1'b1;
            end
            S_DONE:   valid_o = 1'b1;
            default:  ready_o = 1'b0;
        endcase
    end

    assign accept = ready_o & valid_i;

    // u[k] lives at data_i[4-k]; reverse so u_nat[k] is u[k]
    assign u_nat = {msg_q[0], msg_q[1], msg_q[2], msg_q[3], msg_q[4]};

    // interleaver: pick the PERM field for the current step
    always_comb begin
        src2 = 3'd0;
        for (int k = 0; k < INPUT_SIZE; k++) begin
            if (step_q == k[2:0]) src2 = PERM[3*k +: 3];
        end
    end

    assign u1 = (step_q <= LAST_MSG) ? u_nat[step_q] : 1'b0;
    assign u2 = (src2 <= LAST_MSG) ? u_nat[src2] : 1'b0;

    turbo_rsc_step u_rsc1 (
        .s      (enc1_s_q),
        .u      (u1),
        .tail   (tail_en),
        .u_eff  (u1_eff),
        .p      (p1),
        .s_next (enc1_s_d)
    );

    turbo_rsc_step u_rsc2 (
        .s      (enc2_s_q),
        .u      (u2),
        .tail   (tail_en),
        .u_eff  (u2_eff),
        .p      (p2),
        .s_next (enc2_s_d)
    );

    // ---------------- datapath
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            step_q   <= '0;
            msg_q    <= '0;
            enc1_s_q <= '0;
            enc2_s_q <= '0;
            sys1_q   <= '0;
            par1_q   <= '0;
            sys2_q   <= '0;
            par2_q   <= '0;
        end else if (accept) begin
            step_q   <= '0;
            msg_q    <= data_i;
            enc1_s_q <= '0;
            enc2_s_q <= '0;
        end else if (step_en) begin
            step_q   <= step_q + 3'd1;
            enc1_s_q <= enc1_s_d;
            enc2_s_q <= enc2_s_d;
            // symbol 0 ends up in the MSBs after seven shifts
            sys1_q   <= {sys1_q[23:0], sym_map(u1_eff, AMP)};
            par1_q   <= {par1_q[23:0], sym_map(p1, AMP)};
            sys2_q   <= {sys2_q[23:0], sym_map(u2_eff, AMP)};
            par2_q   <= {par2_q[23:0], sym_map(p2, AMP)};
        end
    end

    assign sys1_o = sys1_q;
    assign par1_o = par1_q;
    assign sys2_o = sys2_q;
    assign par2_o = par2_q;

endmodule
